mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-requester round-robin arbiter and sequencer in front of the single-port `memory` block. It shares the memory's `valid`/`ready` interface between ports A and B and captures each winning command into registers. It drives one transaction at a time, returns a one-cycle `ready` pulse with registered read data to the winner, and aborts with an error if the memory stalls beyond a timeout.

## Interface
- `WIDTH`, 16, data width in bits.
- `DEPTH`, 64, memory words.
- `ADDR_WIDTH`, `$clog2(DEPTH)`, address width.
- `TIMEOUT`, 16, maximum cycles waiting for `m_ready` before abort; must be ≥ 2.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `a_valid` in 1: port A request, held until `a_ready`.
- `a_wt_rd` in 1: port A, 1 = write, 0 = read.
- `a_addr` in `ADDR_WIDTH`: port A address.
- `a_wdata` in `WIDTH`: port A write data.
- `a_ready` out 1: port A completion pulse, one cycle.
- `a_rdata` out `WIDTH`: port A read data, valid while `a_ready`=1.
- `a_err` out 1: port A timeout flag, valid while `a_ready`=1.
- `b_valid`, `b_wt_rd`, `b_addr`, `b_wdata`, `b_ready`, `b_rdata`, `b_err`: same as port A, for port B.
- `m_valid` out 1: memory request.
- `m_wt_rd` out 1: memory write/read select.
- `m_addr` out `ADDR_WIDTH`: memory address.
- `m_wdata` out `WIDTH`: memory write data.
- `m_rdata` in `WIDTH`: memory read data.
- `m_ready` in 1: memory completion.
- `busy` out 1: high in MEM or RESP.
- `grant` out 1: owner of current or last transaction, 0 = A, 1 = B.

## Operation
- FSM states:
  - IDLE:
    - If any `*_valid` is high, pick a winner.
    - Latch the winner's `wt_rd`/`addr`/`wdata` into the command registers.
    - Set `grant`, clear the timeout counter, go to MEM.
  - MEM:
    - `m_valid`=1; `m_*` come from the command registers and are stable for the whole state.
    - On `m_ready`=1 at an edge: capture `m_rdata` (reads) or 0 (writes) into the response register, `err`=0, go to RESP.
    - Otherwise, if the counter reaches `TIMEOUT`-1: response = 0, `err`=1, go to RESP.
    - Otherwise increment the counter.
  - RESP:
    - `grant` port's `ready`=1; `rdata`/`err` come from the registers.
    - Go to IDLE unconditionally.
- Arbitration:
  - One request alone: that port wins.
  - Both requesting: the port not equal to `last_grant` wins.
  - `last_grant` updates on every grant; reset value is B, so A wins the first tie.
- Requester changes to `valid`/fields while in MEM are ignored, because the command is already captured.
- A requester must drop or update `valid` by the edge that ends RESP. Requests seen in IDLE are always treated as new.
- The non-granted port's `ready` is 0; its `rdata`/`err` hold their last values.

## Timing
- Reset (`rst`=0, asynchronous):
  - State = IDLE, `last_grant`=B, counter = 0.
  - `m_valid`=0, `m_wt_rd`=0, `m_addr`=0, `m_wdata`=0.
  - `a_ready`=`b_ready`=0, `a_rdata`=`b_rdata`=0, `a_err`=`b_err`=0.
  - `busy`=0, `grant`=0.
- Reset mid-transaction: `m_valid` falls immediately without waiting for a clock edge, and the transaction is lost. No `ready` is issued.
- Latency:
  - Request sampled at edge 0 → `m_valid` high after edge 0.
  - `m_ready` sampled at edge k → port `ready` high for the cycle after edge k.
  - Next grant is possible at edge k+2.
  - Minimum request-to-ready is 2 cycles, when `m_ready` is sampled at edge 1.
  - Back-to-back throughput: one transaction per (memory latency + 2) cycles.
- `m_ready` sampled while not in MEM is ignored.
- Timeout: `m_ready` absent for `TIMEOUT` edges in MEM. The abort edge is MEM entry + `TIMEOUT`, and `m_valid` drops after it.
- Timeout and `m_ready` on the same edge: `m_ready` wins, so `err`=0.

## Structure
- Package `mem_arb_pkg`:
  - State encoding IDLE/MEM/RESP.
  - Port ID constants `PORT_A`=0, `PORT_B`=1.
- Sub-module `rr_arb2`: combinational 2-way round-robin picker.
  - Inputs: `req[1:0]`, `last_grant`.
  - Outputs: `gnt_valid`, `gnt_id`.
- Top holds the FSM, command/response registers, `last_grant` and the timeout counter.

## Test plan
- Single A write `addr`=5, `wdata`=16'hA5A5, memory acks at edge 1 → `a_ready` one cycle, `a_err`=0. B read `addr`=5 afterwards → `b_rdata`=16'hA5A5.
- A and B both hold reads every cycle for 8 transactions → grants alternate A,B,A,B…, starting with A; no port starved.
- Memory holds `m_ready`=0, `TIMEOUT`=16 → `m_valid` high for exactly 16 cycles, then `a_ready`=1, `a_err`=1, `a_rdata`=0; next request is served normally.
- `m_ready` arrives on the same edge the timeout expires → `err`=0 and the data is returned.
- `rst` asserted in MEM → `m_valid`, `busy` and `*_ready` go 0 immediately. After release, a pending B-only request is granted first.
- Port A changes `a_addr` 3→7 while in MEM → `m_addr` stays 3 until RESP.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port memory arbiter: FSM state encoding and port IDs.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MEM  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Combinational 2-way round-robin picker; on a tie the port that did not win last time wins.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       gnt_valid,
  output logic       gnt_id
);

  always_comb begin
    gnt_valid = |req;
    gnt_id    = PORT_A;
    if (req == 2'b11) begin
      gnt_id = ~last_grant;
    end else if (req[1]) begin
      gnt_id = PORT_B;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin sequencer sharing one single-port memory between ports A and B,
// with captured commands, registered one-cycle responses and a stall timeout.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned DEPTH      = 64,
  parameter int unsigned ADDR_WIDTH = $clog2(DEPTH),
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_valid,
  input  logic                  a_wt_rd,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [WIDTH-1:0]      a_wdata,
  output logic                  a_ready,
  output logic [WIDTH-1:0]      a_rdata,
  output logic                  a_err,
  input  logic                  b_valid,
  input  logic                  b_wt_rd,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [WIDTH-1:0]      b_wdata,
  output logic                  b_ready,
  output logic [WIDTH-1:0]      b_rdata,
  output logic                  b_err,
  output logic                  m_valid,
  output logic                  m_wt_rd,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic [WIDTH-1:0]      m_wdata,
  input  logic [WIDTH-1:0]      m_rdata,
  input  logic                  m_ready,
  output logic                  busy,
  output logic                  grant
);

  localparam int unsigned       CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             last_grant_q;
  logic             gnt_valid, gnt_id;
  logic             take, done_ok, done_to, resp_done;
  logic [WIDTH-1:0] resp_data;

  rr_arb2 u_arb (
    .req        ({b_valid, a_valid}),
    .last_grant (last_grant_q),
    .gnt_valid  (gnt_valid),
    .gnt_id     (gnt_id)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next state plus the one-shot events that drive the datapath registers.
  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    done_ok = 1'b0;
    done_to = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (gnt_valid) begin
          take    = 1'b1;
          state_d = ST_MEM;
        end
      end
      ST_MEM: begin
        if (m_ready) begin
          done_ok = 1'b1;
          state_d = ST_RESP;
        end else if (cnt_q == CNT_LAST) begin
          done_to = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    resp_done = done_ok | done_to;
    resp_data = (done_ok && !m_wt_rd) ? m_rdata : '0;
  end

  // Command capture, timeout counter and per-port response registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q        <= '0;
      last_grant_q <= PORT_B;
      grant        <= PORT_A;
      m_valid      <= 1'b0;
      m_wt_rd      <= 1'b0;
      m_addr       <= '0;
      m_wdata      <= '0;
      busy         <= 1'b0;
      a_ready      <= 1'b0;
      a_rdata      <= '0;
      a_err        <= 1'b0;
      b_ready      <= 1'b0;
      b_rdata      <= '0;
      b_err        <= 1'b0;
    end else begin
      m_valid <= (state_d == ST_MEM);
      busy    <= (state_d != ST_IDLE);
      a_ready <= 1'b0;
      b_ready <= 1'b0;
      if (take) begin
        grant        <= gnt_id;
        last_grant_q <= gnt_id;
        cnt_q        <= '0;
        if (gnt_id == PORT_B) begin
          m_wt_rd <= b_wt_rd;
          m_addr  <= b_addr;
          m_wdata <= b_wdata;
        end else begin
          m_wt_rd <= a_wt_rd;
          m_addr  <= a_addr;
          m_wdata <= a_wdata;
        end
      end else if (state_q == ST_MEM && !resp_done) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (resp_done) begin
        if (grant == PORT_B) begin
          b_ready <= 1'b1;
          b_rdata <= resp_data;
          b_err   <= done_to;
        end else begin
          a_ready <= 1'b1;
          a_rdata <= resp_data;
          a_err   <= done_to;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural memory of programmable latency.
module tb_mem_arbiter;

  localparam int WIDTH = 16;
  localparam int AW    = 6;

  logic clk, rst;
  logic a_valid, a_wt_rd, a_ready, a_err;
  logic [AW-1:0] a_addr;
  logic [WIDTH-1:0] a_wdata, a_rdata;
  logic b_valid, b_wt_rd, b_ready, b_err;
  logic [AW-1:0] b_addr;
  logic [WIDTH-1:0] b_wdata, b_rdata;
  logic m_valid, m_wt_rd, m_ready, busy, grant;
  logic [AW-1:0] m_addr;
  logic [WIDTH-1:0] m_wdata, m_rdata;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [WIDTH-1:0] mem_arr [0:63];
  int mem_lat  = 1;
  bit mem_hold = 0;
  int mem_cnt  = 0;

  mem_arbiter #(.WIDTH(16), .DEPTH(64), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_wt_rd(a_wt_rd), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ready(a_ready), .a_rdata(a_rdata), .a_err(a_err),
    .b_valid(b_valid), .b_wt_rd(b_wt_rd), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ready(b_ready), .b_rdata(b_rdata), .b_err(b_err),
    .m_valid(m_valid), .m_wt_rd(m_wt_rd), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ready(m_ready), .busy(busy), .grant(grant)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory acks after mem_lat edges of m_valid, or never while mem_hold is set.
  assign m_rdata = mem_arr[m_addr];
  always @(negedge clk) begin
    if (!m_valid || mem_hold) begin
      m_ready = 1'b0;
      mem_cnt = 0;
    end else if (mem_cnt == mem_lat - 1) begin
      m_ready = 1'b1;
    end else begin
      m_ready = 1'b0;
      mem_cnt = mem_cnt + 1;
    end
  end
  always @(posedge clk) begin
    if (m_valid && m_ready && m_wt_rd) mem_arr[m_addr] = m_wdata;
  end

  task automatic run_txn(input bit port, input bit wt, input logic [AW-1:0] addr,
                         input logic [WIDTH-1:0] wd, output logic [WIDTH-1:0] rd,
                         output logic er, output int cyc, output bit ok);
    @(negedge clk);
    if (port == 1'b0) begin
      a_valid = 1'b1; a_wt_rd = wt; a_addr = addr; a_wdata = wd;
    end else begin
      b_valid = 1'b1; b_wt_rd = wt; b_addr = addr; b_wdata = wd;
    end
    ok = 0; cyc = 0; rd = '0; er = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      cyc++;
      if (port == 1'b0 && a_ready) begin rd = a_rdata; er = a_err; ok = 1; break; end
      if (port == 1'b1 && b_ready) begin rd = b_rdata; er = b_err; ok = 1; break; end
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid got=%b exp=0", m_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_cmp++; if (grant !== 1'b0) begin n_fail++; $display("FAIL reset_grant got=%b exp=0", grant); end
    n_cmp++; if ({a_ready, b_ready, a_err, b_err} !== 4'b0) begin n_fail++; $display("FAIL reset_flags got=%b exp=0000", {a_ready, b_ready, a_err, b_err}); end
    n_cmp++; if ({a_rdata, b_rdata} !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got=%h exp=0", {a_rdata, b_rdata}); end
    n_cmp++; if ({m_wt_rd, m_addr, m_wdata} !== 23'h0) begin n_fail++; $display("FAIL reset_mcmd got=%h exp=0", {m_wt_rd, m_addr, m_wdata}); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write_read();
    logic [WIDTH-1:0] rd; logic er; int cyc; bit ok;
    mem_lat = 1;
    run_txn(1'b0, 1'b1, 6'd5, 16'hA5A5, rd, er, cyc, ok);
    n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL wr_done got=%b exp=1", ok); end
    n_cmp++; if (cyc != 2) begin n_fail++; $display("FAIL wr_latency got=%0d exp=2", cyc); end
    n_cmp++; if (er !== 1'b0) begin n_fail++; $display("FAIL wr_err got=%b exp=0", er); end
    @(negedge clk);
    n_cmp++; if (a_ready !== 1'b0) begin n_fail++; $display("FAIL wr_ready_pulse got=%b exp=0", a_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL wr_busy_after got=%b exp=0", busy); end
    run_txn(1'b1, 1'b0, 6'd5, 16'h0, rd, er, cyc, ok);
    n_cmp++; if (ok !== 1'b1 || rd !== 16'hA5A5) begin n_fail++; $display("FAIL rd_back got=%h exp=a5a5", rd); end
    n_cmp++; if (er !== 1'b0) begin n_fail++; $display("FAIL rd_err got=%b exp=0", er); end
    n_cmp++; if (a_rdata !== 16'h0) begin n_fail++; $display("FAIL a_rdata_hold got=%h exp=0", a_rdata); end
  endtask

  task automatic test_round_robin();
    int seq [8]; logic [WIDTH-1:0] dat [8]; int tstamp [8];
    int n = 0;
    mem_lat = 2;
    @(negedge clk);
    a_valid = 1'b1; a_wt_rd = 1'b0; a_addr = 6'd1;
    b_valid = 1'b1; b_wt_rd = 1'b0; b_addr = 6'd2;
    for (int t = 0; t < 200 && n < 8; t++) begin
      @(negedge clk);
      if (a_ready) begin seq[n] = 0; dat[n] = a_rdata; tstamp[n] = t; n++; end
      else if (b_ready) begin seq[n] = 1; dat[n] = b_rdata; tstamp[n] = t; n++; end
    end
    a_valid = 1'b0; b_valid = 1'b0;
    n_cmp++; if (n != 8) begin n_fail++; $display("FAIL rr_count got=%0d exp=8", n); end
    for (int i = 0; i < n; i++) begin
      n_cmp++; if (seq[i] != i % 2) begin n_fail++; $display("FAIL rr_order[%0d] got=%0d exp=%0d", i, seq[i], i % 2); end
      n_cmp++; if (dat[i] !== ((i % 2 == 0) ? 16'h1001 : 16'h1002)) begin n_fail++; $display("FAIL rr_data[%0d] got=%h", i, dat[i]); end
      if (i > 0) begin
        n_cmp++; if (tstamp[i] - tstamp[i-1] != 4) begin n_fail++; $display("FAIL rr_interval[%0d] got=%0d exp=4", i, tstamp[i] - tstamp[i-1]); end
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_timeout();
    logic [WIDTH-1:0] rd; logic er; int cyc; bit ok;
    int vcnt = 0; bit seen = 0;
    mem_hold = 1;
    @(negedge clk);
    a_valid = 1'b1; a_wt_rd = 1'b0; a_addr = 6'd9;
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      if (m_valid) vcnt++;
      if (a_ready) begin seen = 1; break; end
    end
    n_cmp++; if (seen !== 1'b1) begin n_fail++; $display("FAIL to_ready got=%b exp=1", seen); end
    n_cmp++; if (vcnt != 16) begin n_fail++; $display("FAIL to_mvalid_cycles got=%0d exp=16", vcnt); end
    n_cmp++; if (a_err !== 1'b1) begin n_fail++; $display("FAIL to_err got=%b exp=1", a_err); end
    n_cmp++; if (a_rdata !== 16'h0) begin n_fail++; $display("FAIL to_rdata got=%h exp=0", a_rdata); end
    n_cmp++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL to_mvalid_drop got=%b exp=0", m_valid); end
    a_valid = 1'b0;
    mem_hold = 0; mem_lat = 1;
    run_txn(1'b0, 1'b0, 6'd9, 16'h0, rd, er, cyc, ok);
    n_cmp++; if (ok !== 1'b1 || rd !== 16'h1009 || er !== 1'b0) begin n_fail++; $display("FAIL to_recover got=%h err=%b exp=1009 err=0", rd, er); end
  endtask

  task automatic test_timeout_race();
    logic [WIDTH-1:0] rd; logic er; int cyc; bit ok;
    mem_lat = 16;
    run_txn(1'b1, 1'b0, 6'd3, 16'h0, rd, er, cyc, ok);
    n_cmp++; if (er !== 1'b0) begin n_fail++; $display("FAIL race_err got=%b exp=0", er); end
    n_cmp++; if (rd !== 16'h1003) begin n_fail++; $display("FAIL race_data got=%h exp=1003", rd); end
    n_cmp++; if (cyc != 17) begin n_fail++; $display("FAIL race_latency got=%0d exp=17", cyc); end
  endtask

  task automatic test_reset_mid();
    bit seen = 0;
    mem_hold = 1;
    @(negedge clk);
    a_valid = 1'b1; a_wt_rd = 1'b0; a_addr = 6'd6;
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    n_cmp++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_m_valid got=%b exp=0", m_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    n_cmp++; if ({a_ready, b_ready} !== 2'b00) begin n_fail++; $display("FAIL rstmid_ready got=%b exp=00", {a_ready, b_ready}); end
    a_valid = 1'b0;
    b_valid = 1'b1; b_wt_rd = 1'b0; b_addr = 6'd4;
    mem_hold = 0; mem_lat = 1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (grant !== 1'b1 || m_valid !== 1'b1 || m_addr !== 6'd4) begin n_fail++; $display("FAIL rstmid_regrant got=%b/%b/%0d exp=1/1/4", grant, m_valid, m_addr); end
    for (int t = 0; t < 20; t++) begin
      if (b_ready) begin seen = 1; break; end
      @(negedge clk);
    end
    n_cmp++; if (seen !== 1'b1 || b_rdata !== 16'h1004) begin n_fail++; $display("FAIL rstmid_data got=%h exp=1004", b_rdata); end
    b_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_addr_stable();
    bit seen = 0;
    mem_lat = 4;
    @(negedge clk);
    a_valid = 1'b1; a_wt_rd = 1'b0; a_addr = 6'd3;
    @(negedge clk);
    a_addr = 6'd7;
    for (int t = 0; t < 20; t++) begin
      if (a_ready) begin seen = 1; break; end
      if (m_valid) begin
        n_cmp++; if (m_addr !== 6'd3) begin n_fail++; $display("FAIL addr_stable got=%0d exp=3", m_addr); end
      end
      @(negedge clk);
    end
    n_cmp++; if (seen !== 1'b1 || a_rdata !== 16'h1003) begin n_fail++; $display("FAIL addr_data got=%h exp=1003", a_rdata); end
    a_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem_arr[i] = 16'h1000 + 16'(i);
    m_ready = 1'b0;
    a_valid = 1'b0; a_wt_rd = 1'b0; a_addr = '0; a_wdata = '0;
    b_valid = 1'b0; b_wt_rd = 1'b0; b_addr = '0; b_wdata = '0;
    test_reset();
    test_write_read();
    test_round_robin();
    test_timeout();
    test_timeout_race();
    test_reset_mid();
    test_addr_stable();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
